// File: rtl/addsub_pkg.sv
// addsub_pkg -- shared definitions for the chunked sequential adder/subtractor.
//
// Contents:
//   state_t        controller states (IDLE, RUN)
//   flags_t        status flags that accompany each result
//   DEFAULT_*      default operand width and chunk width
//   split_ok()     elaboration-time check that WIDTH is a whole number of chunks
//   num_chunks()   number of chunks (and so clock cycles) per operation
//   cnt_width()    width of the chunk counter, never zero
package addsub_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
    logic neg;
  } flags_t;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CHUNK = 8;

  // WIDTH must split into an integer number of non-empty chunks.
  function automatic bit split_ok(input int width, input int chunk);
    return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

  function automatic int num_chunks(input int width, input int chunk);
    return width / chunk;
  endfunction

  // A single-chunk configuration still gets a 1-bit counter so the
  // counter never collapses to a zero-width vector.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // The package defaults themselves must be a legal split.
  localparam bit DEFAULTS_OK = split_ok(DEFAULT_WIDTH, DEFAULT_CHUNK);

endpackage

// File: rtl/addsub_seq_adc_chunk.sv
// adc_chunk -- combinational CHUNK-bit add-with-carry slice.
//
// Ports:
//   a, b   [CHUNK-1:0]  chunk operands (b already inverted for subtract)
//   cin                 carry into bit 0 of the chunk
//   sum    [CHUNK-1:0]  chunk sum
//   cout                carry out of the chunk MSB
//   c_msb               carry into the chunk MSB (used for signed overflow)
module adc_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] sum_ext;

  assign sum_ext = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  assign sum     = sum_ext[CHUNK-1:0];
  assign cout    = sum_ext[CHUNK];

  // The sum bit at the MSB is a ^ b ^ carry_in, so the carry into the MSB
  // falls out by XORing the operand bits back off.
  assign c_msb = a[CHUNK-1] ^ b[CHUNK-1] ^ sum_ext[CHUNK-1];

endmodule

// File: rtl/addsub_seq.sv
// addsub_seq -- sequential adder/subtractor that processes CHUNK bits per clock.
//
// An accepted operation takes N = WIDTH/CHUNK cycles; done pulses for one
// cycle with the new result and flags, which then hold until the next done.
//
// Ports:
//   clk                  clock, rising edge
//   rst_n                asynchronous active-low reset
//   start                request, sampled only while ready is high
//   sub                  0 = a + b + cin, 1 = a - b - cin
//   a, b   [WIDTH-1:0]   operands
//   cin                  carry-in (add) / borrow-in (subtract)
//   ready                high when a new start can be accepted
//   done                 one-cycle pulse: result and flags are new
//   result [WIDTH-1:0]   sum / difference
//   cout                 carry out of MSB (subtract: 1 = no borrow)
//   ovf                  two's-complement signed overflow
//   zero                 result is zero
//   neg                  result MSB
module addsub_seq
  import addsub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int N      = num_chunks(WIDTH, CHUNK);
  localparam int CNT_W  = cnt_width(N);
  localparam int BASE_W = $clog2(WIDTH) + 1;

  if (!split_ok(WIDTH, CHUNK)) begin : g_bad_split
    $error("addsub_seq: WIDTH must be a positive integer multiple of CHUNK");
  end

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;       // b already conditioned with sub
  logic [WIDTH-1:0] acc_reg;     // chunk sums gathered so far
  logic             carry_reg;   // carry between chunks
  logic [CNT_W-1:0] idx_reg;

  logic [BASE_W-1:0] base;
  logic [CHUNK-1:0]  chunk_a;
  logic [CHUNK-1:0]  chunk_b;
  logic [CHUNK-1:0]  chunk_sum;
  logic              chunk_cout;
  logic              chunk_c_msb;
  logic [WIDTH-1:0]  acc_next;
  logic              last_chunk;

  assign ready = (state == IDLE);

  // Bit offset of the chunk being processed this cycle.
  assign base    = BASE_W'(idx_reg) * BASE_W'(CHUNK);
  assign chunk_a = a_reg[base +: CHUNK];
  assign chunk_b = b_reg[base +: CHUNK];

  adc_chunk #(
    .CHUNK (CHUNK)
  ) u_adc (
    .a     (chunk_a),
    .b     (chunk_b),
    .cin   (carry_reg),
    .sum   (chunk_sum),
    .cout  (chunk_cout),
    .c_msb (chunk_c_msb)
  );

  // Accumulator with the current chunk sum dropped into place; on the last
  // chunk this is the complete result.
  always_comb begin
    acc_next = acc_reg;
    acc_next[base +: CHUNK] = chunk_sum;
  end

  assign last_chunk = (idx_reg == CNT_W'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
      carry_reg <= 1'b0;
      idx_reg   <= '0;
      done      <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Subtraction is a + ~b + ~borrow, so invert b and the carry
            // here once and run the same adder path for both operations.
            a_reg     <= a;
            b_reg     <= b ^ {WIDTH{sub}};
            carry_reg <= cin ^ sub;
            acc_reg   <= '0;
            idx_reg   <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          acc_reg   <= acc_next;
          carry_reg <= chunk_cout;
          idx_reg   <= idx_reg + CNT_W'(1);
          if (last_chunk) begin
            state  <= IDLE;
            done   <= 1'b1;
            result <= acc_next;
            cout   <= chunk_cout;
            ovf    <= chunk_c_msb ^ chunk_cout;
            zero   <= (acc_next == '0);
            neg    <= acc_next[WIDTH-1];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_seq.sv
// tb_addsub_seq -- directed self-checking bench for addsub_seq.
// u_dut runs the 32/8 configuration, u_dut8 the single-chunk 8/8 one.
module tb_addsub_seq;

  logic        clk;
  logic        rst_n;

  logic        start;
  logic        sub;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        ready;
  logic        done;
  logic [31:0] result;
  logic        cout;
  logic        ovf;
  logic        zero;
  logic        neg;

  logic        s_start;
  logic        s_sub;
  logic [7:0]  s_a;
  logic [7:0]  s_b;
  logic        s_cin;
  logic        s_ready;
  logic        s_done;
  logic [7:0]  s_result;
  logic        s_cout;
  logic        s_ovf;
  logic        s_zero;
  logic        s_neg;

  int checks = 0;
  int errors = 0;

  addsub_seq #(.WIDTH(32), .CHUNK(8)) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .ready  (ready),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf),
    .zero   (zero),
    .neg    (neg)
  );

  addsub_seq #(.WIDTH(8), .CHUNK(8)) u_dut8 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (s_start),
    .sub    (s_sub),
    .a      (s_a),
    .b      (s_b),
    .cin    (s_cin),
    .ready  (s_ready),
    .done   (s_done),
    .result (s_result),
    .cout   (s_cout),
    .ovf    (s_ovf),
    .zero   (s_zero),
    .neg    (s_neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present an operation at a negedge, let the next posedge accept it,
  // then drop start at the following negedge.
  task automatic issue(input logic [31:0] av, input logic [31:0] bv,
                       input logic sv, input logic cv);
    a = av; b = bv; sub = sv; cin = cv; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count rising edges until done is seen at a negedge (bounded).
  task automatic wait_done(output int edges);
    edges = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (done) break;
    end
  endtask

  task automatic test_reset();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=00000000", result); end
    checks++; if ({cout, ovf, zero, neg} !== 4'b0000) begin errors++;
      $display("FAIL reset_flags got=%b exp=0000", {cout, ovf, zero, neg}); end
    $display("reset: ready=%b done=%b result=%h", ready, done, result);
  endtask

  // First start right at reset release, wraparound to zero.
  task automatic test_add_wrap();
    int edges;
    @(negedge clk);
    rst_n = 1'b1;
    issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL wrap_busy got=%b exp=0", ready); end
    wait_done(edges);
    $display("add FFFFFFFF+1: edges=%0d result=%h c=%b v=%b z=%b n=%b", edges, result, cout, ovf, zero, neg);
    checks++; if (edges !== 4) begin errors++; $display("FAIL wrap_latency got=%0d exp=4", edges); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL wrap_result got=%h exp=00000000", result); end
    checks++; if ({cout, ovf, zero, neg} !== 4'b1010) begin errors++;
      $display("FAIL wrap_flags got=%b exp=1010", {cout, ovf, zero, neg}); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL wrap_done_pulse got=%b exp=0", done); end
    checks++; if (result !== 32'h0 || zero !== 1'b1) begin errors++;
      $display("FAIL wrap_hold got=%h/%b exp=00000000/1", result, zero); end
  endtask

  // Signed overflow; inputs are scrambled after acceptance.
  task automatic test_overflow();
    int edges;
    issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    a = 32'hDEAD_BEEF; b = 32'h1234_5678; sub = 1'b1; cin = 1'b1;
    wait_done(edges);
    $display("add 7FFFFFFF+1: edges=%0d result=%h c=%b v=%b z=%b n=%b", edges, result, cout, ovf, zero, neg);
    checks++; if (edges !== 4) begin errors++; $display("FAIL ovf_latency got=%0d exp=4", edges); end
    checks++; if (result !== 32'h8000_0000) begin errors++; $display("FAIL ovf_result got=%h exp=80000000", result); end
    checks++; if ({cout, ovf, zero, neg} !== 4'b0101) begin errors++;
      $display("FAIL ovf_flags got=%b exp=0101", {cout, ovf, zero, neg}); end
  endtask

  task automatic test_subtract();
    int edges;
    issue(32'd5, 32'd7, 1'b1, 1'b0);
    wait_done(edges);
    $display("sub 5-7-0: edges=%0d result=%h c=%b v=%b z=%b n=%b", edges, result, cout, ovf, zero, neg);
    checks++; if (result !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub_result got=%h exp=fffffffe", result); end
    checks++; if ({cout, ovf, zero, neg} !== 4'b0001) begin errors++;
      $display("FAIL sub_flags got=%b exp=0001", {cout, ovf, zero, neg}); end
    issue(32'd5, 32'd7, 1'b1, 1'b1);
    wait_done(edges);
    $display("sub 5-7-1: edges=%0d result=%h c=%b v=%b z=%b n=%b", edges, result, cout, ovf, zero, neg);
    checks++; if (result !== 32'hFFFF_FFFD) begin errors++; $display("FAIL subb_result got=%h exp=fffffffd", result); end
    checks++; if ({cout, ovf, zero, neg} !== 4'b0001) begin errors++;
      $display("FAIL subb_flags got=%b exp=0001", {cout, ovf, zero, neg}); end
    // Equal operands without borrow: carry set (no borrow), zero set.
    issue(32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0);
    wait_done(edges);
    $display("sub x-x: edges=%0d result=%h c=%b v=%b z=%b n=%b", edges, result, cout, ovf, zero, neg);
    checks++; if (result !== 32'h0 || {cout, ovf, zero, neg} !== 4'b1010) begin errors++;
      $display("FAIL subeq got=%h/%b exp=00000000/1010", result, {cout, ovf, zero, neg}); end
    // Chunk-boundary carries: 0x00FF00FF + 0x00010001 + 1.
    issue(32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b1);
    wait_done(edges);
    $display("add carry chain: edges=%0d result=%h", edges, result);
    checks++; if (result !== 32'h0100_0101) begin errors++; $display("FAIL chain_result got=%h exp=01000101", result); end
  endtask

  // Starts during RUN are ignored; a start in the done cycle is accepted.
  task automatic test_back_to_back();
    int edges;
    issue(32'd1, 32'd2, 1'b0, 1'b0);
    a = 32'd9; b = 32'd9; start = 1'b1;
    wait_done(edges);
    $display("add 1+2 with ignored starts: edges=%0d result=%h", edges, result);
    checks++; if (edges !== 4) begin errors++; $display("FAIL b2b_first_latency got=%0d exp=4", edges); end
    checks++; if (result !== 32'h3) begin errors++; $display("FAIL b2b_first_result got=%h exp=00000003", result); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_in_done got=%b exp=1", ready); end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL b2b_accepted got=%b exp=0", ready); end
    checks++; if (result !== 32'h3 || done !== 1'b0) begin errors++;
      $display("FAIL b2b_hold got=%h/%b exp=00000003/0", result, done); end
    wait_done(edges);
    $display("add 9+9 back-to-back: edges=%0d result=%h", edges, result);
    checks++; if (edges !== 4) begin errors++; $display("FAIL b2b_second_latency got=%0d exp=4", edges); end
    checks++; if (result !== 32'h12) begin errors++; $display("FAIL b2b_second_result got=%h exp=00000012", result); end
  endtask

  task automatic test_reset_mid_run();
    int pulses;
    issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    $display("reset mid-run: ready=%b done=%b result=%h", ready, done, result);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL abort_ready got=%b exp=1", ready); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL abort_result got=%h exp=00000000", result); end
    checks++; if ({done, cout, ovf, zero, neg} !== 5'b00000) begin errors++;
      $display("FAIL abort_flags got=%b exp=00000", {done, cout, ovf, zero, neg}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", pulses); end
    // Operation right after reset must run normally.
    issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    wait_done(pulses);
    $display("add after reset: edges=%0d result=%h", pulses, result);
    checks++; if (result !== 32'h2345_6789) begin errors++; $display("FAIL after_reset_result got=%h exp=23456789", result); end
  endtask

  task automatic test_single_chunk();
    int edges;
    s_a = 8'h80; s_b = 8'h01; s_sub = 1'b1; s_cin = 1'b0; s_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_start = 1'b0;
    edges = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (s_done) break;
    end
    $display("w8 sub 80-1: edges=%0d result=%h c=%b v=%b z=%b n=%b", edges, s_result, s_cout, s_ovf, s_zero, s_neg);
    checks++; if (edges !== 1) begin errors++; $display("FAIL n1_latency got=%0d exp=1", edges); end
    checks++; if (s_result !== 8'h7F) begin errors++; $display("FAIL n1_result got=%h exp=7f", s_result); end
    checks++; if ({s_cout, s_ovf, s_zero, s_neg} !== 4'b1100) begin errors++;
      $display("FAIL n1_flags got=%b exp=1100", {s_cout, s_ovf, s_zero, s_neg}); end
    // Back-to-back in the done cycle at N=1: 0x7F + 0x01 overflows.
    s_a = 8'h7F; s_b = 8'h01; s_sub = 1'b0; s_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    $display("w8 add 7F+1: done=%b result=%h c=%b v=%b n=%b", s_done, s_result, s_cout, s_ovf, s_neg);
    checks++; if (s_done !== 1'b1 || s_result !== 8'h80) begin errors++;
      $display("FAIL n1_b2b got=%b/%h exp=1/80", s_done, s_result); end
    checks++; if ({s_cout, s_ovf, s_zero, s_neg} !== 4'b0101) begin errors++;
      $display("FAIL n1_b2b_flags got=%b exp=0101", {s_cout, s_ovf, s_zero, s_neg}); end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
    s_start = 1'b0; s_sub = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_add_wrap();
    test_overflow();
    test_subtract();
    test_back_to_back();
    test_reset_mid_run();
    test_single_chunk();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
